// File: rtl/ipsxe_floating_point_fl2fx_rnd_ctrl_v1_0.sv
// Float-to-fixed sequencer: serial 1-bit/cycle mantissa alignment, round-to-nearest-even, saturation.
// Latency: m_valid n+2 cycles after accept (n = |alignment shift|); special/overflow/underflow paths 1 cycle.
// Backpressure: one conversion in flight; s_ready only in IDLE, result held in DONE until m_ready.
//
// Ports: i_aclk/i_rst_n (async active-low), s_valid/s_ready/s_data {sign,exp,frac},
//        m_valid/m_ready/m_data (two's complement Q FIX_INT_BIT.FIX_FRAC_BIT), m_overflow, m_invalid.
// Optional macro FL2FX_INEXACT_FLAG_EN adds m_inexact (residue nonzero or saturated; 0 for NaN).
module ipsxe_floating_point_fl2fx_rnd_ctrl_v1_0 #(
  parameter int FLOAT_EXP_BIT  = 8,
  parameter int FLOAT_FRAC_BIT = 24,
  parameter int FIX_INT_BIT    = 16,
  parameter int FIX_FRAC_BIT   = 16
) (
  input  logic                                  i_aclk,
  input  logic                                  i_rst_n,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [FLOAT_EXP_BIT+FLOAT_FRAC_BIT-1:0] s_data,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [FIX_INT_BIT+FIX_FRAC_BIT-1:0]   m_data,
  output logic                                  m_overflow,
`ifdef FL2FX_INEXACT_FLAG_EN
  output logic                                  m_inexact,
`endif
  output logic                                  m_invalid
);

  localparam int FW    = FLOAT_EXP_BIT + FLOAT_FRAC_BIT;
  localparam int FIX_W = FIX_INT_BIT + FIX_FRAC_BIT;
  localparam int MW    = FIX_W + 1;               // headroom for the rounding carry
  localparam int RW    = FLOAT_FRAC_BIT + 1;      // residue width
  localparam int CW    = $clog2(FIX_W + FLOAT_FRAC_BIT + 2);
  localparam int BIAS  = (1 << (FLOAT_EXP_BIT - 1)) - 1;

  localparam logic [RW-1:0]    HALF    = {1'b1, {(RW-1){1'b0}}};
  localparam logic [MW-1:0]    LIM_POS = {2'b00, {(FIX_W-1){1'b1}}};
  localparam logic [MW-1:0]    LIM_NEG = {2'b01, {(FIX_W-1){1'b0}}};
  localparam logic [FIX_W-1:0] MAX_POS = {1'b0, {(FIX_W-1){1'b1}}};
  localparam logic [FIX_W-1:0] MIN_NEG = {1'b1, {(FIX_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t              state;
  logic                neg;
  logic                left;
  logic [CW-1:0]       cnt;
  logic [MW-1:0]       mag;
  logic [RW-1:0]       residue;

  // Input field decode
  logic                       in_sign;
  logic [FLOAT_EXP_BIT-1:0]   in_exp;
  logic [FLOAT_FRAC_BIT-2:0]  in_frac;
  logic                       exp_max;
  logic                       frac_zero;
  logic signed [31:0]         e_val;
  logic signed [31:0]         sh_val;
  logic signed [31:0]         sh_abs;
  logic                       is_nan;
  logic                       is_ovf;
  logic                       is_unf;

  assign in_sign   = s_data[FW-1];
  assign in_exp    = s_data[FW-2 -: FLOAT_EXP_BIT];
  assign in_frac   = s_data[FLOAT_FRAC_BIT-2:0];
  assign exp_max   = &in_exp;
  assign frac_zero = (in_frac == '0);

  always_comb begin
    e_val  = (in_exp == '0) ? (32'sd1 - BIAS) : ($signed(32'(in_exp)) - BIAS);
    sh_val = e_val - (FLOAT_FRAC_BIT - 1) + FIX_FRAC_BIT;
    sh_abs = (sh_val < 0) ? -sh_val : sh_val;
    is_nan = exp_max && !frac_zero;
    // E == FIX_INT_BIT-1 only fits for exactly -2^(FIX_INT_BIT-1)
    is_ovf = exp_max || (e_val > FIX_INT_BIT - 1) ||
             ((e_val == FIX_INT_BIT - 1) && !(in_sign && frac_zero));
    is_unf = (sh_val < -(FLOAT_FRAC_BIT + 1));
  end

  // Round-to-nearest-even and saturation on the aligned magnitude
  logic             inc;
  logic [MW-1:0]    sum;
  logic             rnd_ovf;
  logic [FIX_W-1:0] rnd_val;

  always_comb begin
    inc     = (residue > HALF) || ((residue == HALF) && mag[0]);
    sum     = mag + MW'(inc);
    rnd_ovf = sum > (neg ? LIM_NEG : LIM_POS);
    rnd_val = neg ? (FIX_W'(0) - sum[FIX_W-1:0]) : sum[FIX_W-1:0];
  end

  assign s_ready = (state == IDLE);

  always_ff @(posedge i_aclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      neg        <= 1'b0;
      left       <= 1'b0;
      cnt        <= '0;
      mag        <= '0;
      residue    <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_overflow <= 1'b0;
      m_invalid  <= 1'b0;
`ifdef FL2FX_INEXACT_FLAG_EN
      m_inexact  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            neg        <= in_sign;
            m_overflow <= 1'b0;
            m_invalid  <= 1'b0;
`ifdef FL2FX_INEXACT_FLAG_EN
            m_inexact  <= 1'b0;
`endif
            if (is_nan) begin
              m_data    <= '0;
              m_invalid <= 1'b1;
              state     <= DONE;
            end else if (is_ovf) begin
              m_data     <= in_sign ? MIN_NEG : MAX_POS;
              m_overflow <= 1'b1;
`ifdef FL2FX_INEXACT_FLAG_EN
              m_inexact  <= 1'b1;
`endif
              state      <= DONE;
            end else if (is_unf) begin
              m_data <= '0;
`ifdef FL2FX_INEXACT_FLAG_EN
              m_inexact <= (in_exp != '0) || !frac_zero;
`endif
              state  <= DONE;
            end else begin
              mag     <= MW'({(in_exp != '0), in_frac});
              residue <= '0;
              left    <= (sh_val > 0);
              cnt     <= CW'(sh_abs);
              state   <= (sh_val == 0) ? ROUND : SHIFT;
            end
          end
        end
        SHIFT: begin
          if (left) begin
            mag <= mag << 1;
          end else begin
            mag     <= mag >> 1;
            // LSB stays sticky so anything pushed past it is remembered
            residue <= {mag[0], residue[RW-1:2], residue[1] | residue[0]};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= ROUND;
        end
        ROUND: begin
          m_data     <= rnd_ovf ? (neg ? MIN_NEG : MAX_POS) : rnd_val;
          m_overflow <= rnd_ovf;
`ifdef FL2FX_INEXACT_FLAG_EN
          m_inexact  <= (residue != '0) || rnd_ovf;
`endif
          state      <= DONE;
        end
        DONE: begin
          // First DONE cycle raises m_valid; later cycles wait for the consumer
          if (!m_valid) begin
            m_valid <= 1'b1;
          end else if (m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
